// File: rtl/attention_head_feeder.sv
// attention_head_feeder: buffers up to DEPTH tokens with their four per-head
// biases, then streams them to the attention block with en held high, pads
// with zeros until end_flag, and pulses done.
// Optional build macro: FEEDER_TIMEOUT_EN adds a WAIT_END watchdog that
// raises the sticky err flag after TIMEOUT cycles without end_flag.

package definition;
    localparam int att_width = 16;
endpackage

module attention_head_feeder
    import definition::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [att_width-1:0]     wr_data,
    input  logic [4*att_width-1:0]   wr_bias,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   len,
    output logic [att_width-1:0]     i_4head,
    output logic [att_width-1:0]     bias_1,
    output logic [att_width-1:0]     bias_2,
    output logic [att_width-1:0]     bias_3,
    output logic [att_width-1:0]     bias_4,
    output logic                     en,
    input  logic                     end_flag,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    // state    | meaning
    // IDLE     | buffer writable, waiting for a start with a legal len
    // STREAM   | presenting buffer entry idx, en high
    // WAIT_END | zeros presented, en high, waiting for end_flag
    // DONE     | done pulse cycle, start ignored

    localparam int IW = $clog2(DEPTH);
    localparam int LW = IW + 1;
    localparam int EW = 5 * att_width;

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_END, DONE} state_t;

    state_t        state;
    logic [EW-1:0] mem [DEPTH];
    logic [IW-1:0] idx;
    logic [LW-1:0] len_q;
    logic          len_ok;
    logic          start_ok;
    logic          last;
    logic [IW-1:0] idx_nxt;
    logic [EW-1:0] entry_nxt;

`ifdef FEEDER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
`endif

    // Elaboration-time sanity check on the parameters.
    if (DEPTH < 2 || TIMEOUT < 1) begin : g_param_check
        $error("attention_head_feeder: DEPTH must be >= 2 and TIMEOUT >= 1");
    end

    // Start qualification and next-entry lookup.
    always_comb begin
        len_ok    = (len != '0) && (len <= LW'(DEPTH));
        start_ok  = (state == IDLE) && start && len_ok;
        last      = (LW'(idx) == (len_q - LW'(1)));
        idx_nxt   = idx + IW'(1);
        entry_nxt = mem[idx_nxt];
    end

    // Token buffer: writable only while idle and not being started this edge.
    // Entry layout is {bias_4, bias_3, bias_2, bias_1, token}.
    always_ff @(posedge clk) begin
        if (wr_en && (state == IDLE) && !start_ok) begin
            mem[wr_addr] <= {wr_bias, wr_data};
        end
    end

    // Sequencer with registered datapath outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            idx     <= '0;
            len_q   <= '0;
            i_4head <= '0;
            bias_1  <= '0;
            bias_2  <= '0;
            bias_3  <= '0;
            bias_4  <= '0;
            en      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        len_q <= len;
                        idx   <= '0;
                        err   <= 1'b0;
                        en    <= 1'b1;
                        busy  <= 1'b1;
                        {bias_4, bias_3, bias_2, bias_1, i_4head} <= mem[0];
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (last) begin
                        {bias_4, bias_3, bias_2, bias_1, i_4head} <= '0;
`ifdef FEEDER_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                        state <= WAIT_END;
                    end else begin
                        idx <= idx_nxt;
                        {bias_4, bias_3, bias_2, bias_1, i_4head} <= entry_nxt;
                    end
                end
                WAIT_END: begin
                    if (end_flag) begin
                        en    <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
`ifdef FEEDER_TIMEOUT_EN
                    else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        en    <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
`endif
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_attention_head_feeder.sv
// Directed bench for attention_head_feeder with a scoreboard of expected
// output beats filled from a bench-side model of the token buffer.

module tb_attention_head_feeder;
    import definition::*;

    localparam int W     = att_width;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int OW    = 1 + 5 * W;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic [4*W-1:0] wr_bias = '0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic [W-1:0]  i_4head, bias_1, bias_2, bias_3, bias_4;
    logic          en, end_flag = 1'b0, busy, done, err;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [OW-1:0]  exp_q [$];
    logic [5*W-1:0] model [DEPTH];

    attention_head_feeder #(.DEPTH(DEPTH), .TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_bias(wr_bias), .start(start), .len(len),
        .i_4head(i_4head), .bias_1(bias_1), .bias_2(bias_2),
        .bias_3(bias_3), .bias_4(bias_4), .en(en), .end_flag(end_flag),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] obs_vec();
        return {en, i_4head, bias_1, bias_2, bias_3, bias_4};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_out(input string tag);
        if (exp_q.size() == 0) begin
            n_total++;
            n_fail++;
            $error("FAIL %s: observed %h expected <no beat queued>", tag, obs_vec());
        end else begin
            check(tag, obs_vec(), exp_q.pop_front());
        end
    endtask

    task automatic wr(input int a, input logic [W-1:0] tok, input logic [W-1:0] b1,
                      input logic [W-1:0] b2, input logic [W-1:0] b3, input logic [W-1:0] b4);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = tok;
        wr_bias = {b4, b3, b2, b1};
        model[a] = {b4, b3, b2, b1, tok};
        step();
        wr_en = 1'b0;
    endtask

    task automatic push_entry(input int k);
        logic [5*W-1:0] e;
        e = model[k];
        exp_q.push_back({1'b1, e[W-1:0], e[2*W-1:W], e[3*W-1:2*W], e[4*W-1:3*W], e[5*W-1:4*W]});
    endtask

    // One complete run: n tokens, extra zero cycles before end_flag, or
    // end_flag held high from the first STREAM cycle (early), optionally
    // attempting a buffer write while streaming.
    task automatic run_stream(input int n, input int extra, input bit early, input bit wr_mid, input string name);
        for (int k = 0; k < n; k++) push_entry(k);
        start = 1'b1;
        len   = LW'(n);
        step();
        start = 1'b0;
        if (early) end_flag = 1'b1;
        check({name, "_busy_err"}, OW'({busy, err}), OW'(2'b10));
        for (int k = 0; k < n; k++) begin
            if (wr_mid && k == 0) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = W'(9);
                wr_bias = '0;
            end
            check_out($sformatf("%s_tok%0d", name, k));
            step();
            wr_en = 1'b0;
        end
        check({name, "_zero0"}, obs_vec(), {1'b1, {(5*W){1'b0}}});
        if (!early) begin
            for (int i = 0; i < extra; i++) begin
                step();
                check($sformatf("%s_zero%0d", name, i + 1), obs_vec(), {1'b1, {(5*W){1'b0}}});
            end
            end_flag = 1'b1;
        end
        step();
        end_flag = 1'b0;
        check({name, "_done_pulse"}, OW'({en, done, busy}), OW'(3'b011));
        step();
        check({name, "_idle"}, OW'({en, done, busy, err}), OW'(4'b0000));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", OW'({en, busy, done, err}), OW'(4'b0000));
        check("reset_data", obs_vec(), '0);
        rstn = 1'b1;
        step();

        // Basic four-token run.
        for (int k = 0; k < 4; k++)
            wr(k, W'(k + 1), W'(k + 4), W'(k + 4), W'(k + 4), W'(k + 4));
        run_stream(4, 4, 1'b0, 1'b0, "basic");

        // Out-of-range lengths are ignored.
        start = 1'b1;
        len   = '0;
        step();
        check("len0_busy", OW'({busy, en}), OW'(2'b00));
        check("len0_data", obs_vec(), '0);
        len = LW'(DEPTH + 1);
        step();
        check("lenbig_busy", OW'({busy, en}), OW'(2'b00));
        check("lenbig_data", obs_vec(), '0);
        start = 1'b0;
        step();

        // Write during STREAM is dropped; the next len=1 run shows old entry 0.
        run_stream(4, 0, 1'b0, 1'b1, "wrmid");
        run_stream(1, 2, 1'b0, 1'b0, "len1");

        // end_flag already high while streaming.
        run_stream(4, 0, 1'b1, 1'b0, "early");

        // Reset on the third token cycle.
        for (int k = 0; k < 4; k++) push_entry(k);
        start = 1'b1;
        len   = LW'(4);
        step();
        start = 1'b0;
        check_out("rst_tok0");
        step();
        check_out("rst_tok1");
        step();
        check_out("rst_tok2");
        #2 rstn = 1'b0;
        #1;
        check("rst_async_ctrl", OW'({en, busy, done}), OW'(3'b000));
        check("rst_async_data", obs_vec(), '0);
        exp_q.delete();
        #2 rstn = 1'b1;
        step();
        check("rst_idle", OW'({en, busy, done}), OW'(3'b000));
        wr(0, W'(11), W'(21), W'(22), W'(23), W'(24));
        wr(1, W'(12), W'(31), W'(32), W'(33), W'(34));
        run_stream(2, 1, 1'b0, 1'b0, "post_rst");

        // Full-depth run.
        for (int k = 0; k < DEPTH; k++)
            wr(k, W'(100 + k), W'(200 + k), W'(300 + k), W'(400 + k), W'(500 + k));
        run_stream(DEPTH, 0, 1'b0, 1'b0, "full");

`ifdef FEEDER_TIMEOUT_EN
        // Watchdog: no end_flag, timeout after 8 WAIT_END cycles.
        push_entry(0);
        start = 1'b1;
        len   = LW'(1);
        step();
        start = 1'b0;
        check_out("to_tok0");
        step();
        check("to_wait0", obs_vec(), {1'b1, {(5*W){1'b0}}});
        for (int i = 1; i < 8; i++) begin
            step();
            check($sformatf("to_wait%0d", i), OW'({en, done, err}), OW'(3'b100));
        end
        step();
        check("to_fire", OW'({en, done, err, busy}), OW'(4'b0111));
        step();
        check("to_idle", OW'({en, done, err, busy}), OW'(4'b0010));
        run_stream(1, 0, 1'b1, 1'b0, "to_clear");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/attention_head_feeder.md
# attention_head_feeder

Stream source for `Attention_4head`: buffers up to `DEPTH` input tokens together with their four per-head biases, then streams them in order on `i_4head`/`bias_1..bias_4` with `en` held high. It flushes zeros until the attention block raises `end_flag`, then reports completion. It sits between the token/bias loader and the attention datapath, on the driving side of the `i_4head`/`bias_n`/`en`/`end_flag` interface.

## Interface
Parameters:
- `DEPTH`, 16: token buffer entries (≥2).
- `TIMEOUT`, 1023: `WAIT_END` watchdog limit in cycles. Used only with `FEEDER_TIMEOUT_EN`.
- Data width is `att_width` from package `definition` (imported), not a parameter.

Ports:
- `clk` in 1: clock, rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: buffer write strobe.
- `wr_addr` in $clog2(DEPTH): buffer write address.
- `wr_data` in att_width: token value.
- `wr_bias` in 4*att_width: biases; [att_width-1:0] is head 1, ascending to head 4.
- `start` in 1: begin stream (level sampled in `IDLE`).
- `len` in $clog2(DEPTH)+1: token count, valid range 1..DEPTH.
- `i_4head` out att_width: token to attention.
- `bias_1..bias_4` out att_width each: per-head bias.
- `en` out 1: attention enable.
- `end_flag` in 1: attention completion.
- `busy` out 1: high in any state other than `IDLE`.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky watchdog flag.

## Operation
- Buffer: `DEPTH` × 5·att_width register array.
  - A write with `wr_en` commits at the edge only in `IDLE` and only if no start is accepted that same edge.
  - Writes in any other state are dropped.
- States: `IDLE`, `STREAM`, `WAIT_END`, `DONE`.
- `IDLE`:
  - `start` with 1 ≤ `len` ≤ DEPTH: latch `len`, clear index, clear `err`, go to `STREAM`. At this edge, `i_4head`/`bias_n` load entry 0 and `en` goes to 1.
  - Out-of-range `len` (0 or >DEPTH): start ignored, state unchanged, no output change.
- `STREAM`:
  - Each edge advances the index and loads the next entry.
  - After entry `len`-1 has been presented for one cycle, the outputs load 0 and the state goes to `WAIT_END`. `en` stays 1.
  - `end_flag` is ignored in this state.
- `WAIT_END`: data and bias outputs held at 0, `en`=1. When `end_flag`=1 is sampled: `en`←0, `done`←1, go to `DONE`.
- `DONE`: `done`←0, go to `IDLE`. `start` is ignored in this state.
- All outputs are registered.

## Timing
- Reset (async, immediate): state `IDLE`, `i_4head`=`bias_n`=0, `en`=`busy`=`done`=`err`=0. Buffer contents are undefined after reset.
- Start accepted at edge E0: token k is valid in the cycle after edge E0+k, for k = 0..len-1.
- Zeros appear after edge E0+len. `busy` rises after E0.
- `end_flag` sampled at edge Ef:
  - `en`=0 and `done`=1 in the following cycle.
  - `busy` stays 1 through `DONE` and falls one cycle later.
- Minimum start-to-start spacing: len+3 cycles, assuming `end_flag` is already high on the first `WAIT_END` cycle.
- `len`=1: single token cycle, then `WAIT_END`.
- `len`=DEPTH: index reaches DEPTH-1 without wrap.
- Reset asserted mid-stream: `en` drops asynchronously; stream is abandoned with no `done`.

## Configuration
- `FEEDER_TIMEOUT_EN` defined:
  - A counter runs in `WAIT_END` and clears on entry.
  - If it reaches `TIMEOUT` with no `end_flag`: `en`←0, `err`←1 (held until the next accepted start), `done` pulses, state goes to `DONE`.
  - If `end_flag` and the timeout coincide, `end_flag` wins and `err` stays 0.
- Not defined: no counter, `err` tied 0, `WAIT_END` waits indefinitely.

## Test plan
- Load entries 0..3 = (token 1, biases 4), (2, 5), (3, 6), (4, 7); start with `len`=4. Required:
  - `i_4head` = 1,2,3,4 on consecutive cycles with `bias_1..4` = 4,5,6,7.
  - Then 0 with `en`=1.
  - `end_flag` pulse 5 cycles later → `en`=0 and a single `done` pulse.
- `len`=0 and `len`=DEPTH+1 with `start`: `busy` stays 0, outputs stay 0.
- Write to address 0 with value 9 during `STREAM`: the next run with `len`=1 still outputs the old entry 0.
- `end_flag` high during `STREAM` (`len`=4): ignored, all 4 tokens emitted, completion at the first `WAIT_END` sample.
- `rstn` low on the third token cycle: `en`, `busy` and outputs are 0 before the next edge; a subsequent start with `len`=2 streams correctly.
- With `FEEDER_TIMEOUT_EN` and `TIMEOUT`=8, `end_flag` never raised: `en` drops 8 cycles into `WAIT_END`, `err`=1, `done` pulses; the next accepted start clears `err`.
